// File: rtl/topk_sorted_tracker_if.sv
// Query-side bus of the top-K tracker: candidate stream in, sorted neighbour list out.
// in_valid/in_ready: a pair transfers on a rising edge where both are high and start is low.
interface topk_sorted_tracker_if #(
    parameter int K  = 5,
    parameter int DW = 32,
    parameter int LW = 4
);
    localparam int CW = $clog2(K + 1);

    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [DW-1:0]   in_dist;
    logic [LW-1:0]   in_label;
    logic [K*DW-1:0] topk_dist;
    logic [K*LW-1:0] topk_label;
    logic [K-1:0]    topk_vld;
    logic [CW-1:0]   count;
    logic            result_valid;

    modport master (
        output start, in_valid, in_last, in_dist, in_label,
        input  in_ready, topk_dist, topk_label, topk_vld, count, result_valid
    );

    modport slave (
        input  start, in_valid, in_last, in_dist, in_label,
        output in_ready, topk_dist, topk_label, topk_vld, count, result_valid
    );
endinterface

// File: rtl/topk_sorted_tracker.sv
// Streaming keeper of the K smallest (distance, label) pairs, held sorted ascending.
// One pair per cycle is compared against all slots and inserted by a single shift.
module topk_sorted_tracker #(
    parameter int K  = 5,
    parameter int DW = 32,
    parameter int LW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    topk_sorted_tracker_if.slave  bus,
    output logic [1:0]            o_dbg_state
);
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DONE = 2'd2} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_in_ready;
    logic            w_result_valid;
    logic            w_accept;

    logic [DW-1:0]   r_dist  [K];
    logic [LW-1:0]   r_label [K];
    logic [K-1:0]    r_vld;
    logic [CW-1:0]   r_count;

    logic [K-1:0]    w_le;
    logic [K-1:0]    w_prev_le;
    logic [DW-1:0]   w_dist_n  [K];
    logic [LW-1:0]   w_label_n [K];
    logic [K-1:0]    w_vld_n;
    logic [K*DW-1:0] w_topk_dist;
    logic [K*LW-1:0] w_topk_label;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.start) begin
            w_next_state = S_ACCUM;
        end else begin
            case (r_state)
                S_ACCUM: if (bus.in_valid && bus.in_last) w_next_state = S_DONE;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        w_in_ready     = (r_state == S_ACCUM);
        w_result_valid = (r_state == S_DONE);
    end

    assign w_accept = bus.in_valid && w_in_ready && !bus.start;

    // Sorted, contiguous occupancy makes w_le a thermometer: ones below the insert slot.
    // Empty slots never count as <=, so they lose to any candidate.
    always_comb begin
        w_le      = '0;
        w_prev_le = '0;
        for (int i = 0; i < K; i++) begin
            w_le[i] = r_vld[i] && (r_dist[i] <= bus.in_dist);
        end
        w_prev_le[0] = 1'b1;
        for (int i = 1; i < K; i++) begin
            w_prev_le[i] = w_le[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_dist_n[i]  = r_dist[i];
            w_label_n[i] = r_label[i];
            w_vld_n[i]   = r_vld[i];
            if (!w_le[i] && w_prev_le[i]) begin
                w_dist_n[i]  = bus.in_dist;
                w_label_n[i] = bus.in_label;
                w_vld_n[i]   = 1'b1;
            end
        end
        for (int i = 1; i < K; i++) begin
            if (!w_le[i] && !w_prev_le[i]) begin
                w_dist_n[i]  = r_dist[i-1];
                w_label_n[i] = r_label[i-1];
                w_vld_n[i]   = r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.start) begin
            for (int i = 0; i < K; i++) begin
                r_dist[i]  <= '1;
                r_label[i] <= '0;
            end
            r_vld   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < K; i++) begin
                r_dist[i]  <= w_dist_n[i];
                r_label[i] <= w_label_n[i];
            end
            r_vld <= w_vld_n;
            if (r_count != CW'(K)) r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        w_topk_dist  = '0;
        w_topk_label = '0;
        for (int i = 0; i < K; i++) begin
            w_topk_dist[i*DW +: DW]  = r_dist[i];
            w_topk_label[i*LW +: LW] = r_label[i];
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.result_valid = w_result_valid;
    assign bus.topk_dist    = w_topk_dist;
    assign bus.topk_label   = w_topk_label;
    assign bus.topk_vld     = r_vld;
    assign bus.count        = r_count;
    assign o_dbg_state      = r_state;
endmodule
